// File: rtl/spi_master_byte_if.sv
// ---------------------------------------------------------------------------
// spi_master_byte_if
//   Bundles the signals of spi_master_byte apart from clk and rst_L.
//   User side (byte handshake):
//     tx_data/tx_hold/tx_valid : byte offered by the requester
//     tx_ready                 : controller idle, byte will be accepted
//     rx_data/rx_valid         : received byte, rx_valid pulses for one cycle
//     busy                     : transfer or CS gap in progress
//   SPI side:
//     sclk/mosi/cs_L           : driven by the controller
//     miso                     : returned by the peripheral (already synchronised)
//   Modports:
//     master : the controller's view
//     slave  : the view of whatever sits opposite the controller
//              (requester plus peripheral, e.g. a bench)
// ---------------------------------------------------------------------------
interface spi_master_byte_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_hold;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_L;

  modport master (
    input  tx_data, tx_hold, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_L
  );

  modport slave (
    output tx_data, tx_hold, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_L
  );
endinterface

// File: rtl/spi_master_byte.sv
// ---------------------------------------------------------------------------
// spi_master_byte
//   SPI mode-0 (CPOL=0, CPHA=0), MSB-first bus initiator. Each byte accepted
//   on the valid/ready handshake becomes one full-duplex WIDTH-bit transfer.
//   A byte sent with tx_hold=1 leaves cs_L asserted afterwards so the next
//   byte continues the same chip-select frame.
//
//   Ports:
//     clk    : system clock, all logic on posedge
//     rst_L  : asynchronous active-low reset
//     bus    : spi_master_byte_if.master (handshake + SPI pins)
//
//   Parameters:
//     CLK_DIV : clk cycles per sclk half-period (>= 2)
//     WIDTH   : bits per transfer
//
//   Timeline relative to accept edge T0, with D = CLK_DIV:
//     sclk rises at T0+D*(2k+1) (miso sampled there), falls at T0+D*(2k+2)
//     rx_valid pulse at T0+(2*WIDTH+1)*D
//     tx_ready back at T0+(2*WIDTH+2)*D (or one D earlier when holding CS)
// ---------------------------------------------------------------------------
module spi_master_byte #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_L,
  spi_master_byte_if.master     bus
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_master_byte: CLK_DIV must be >= 2");
  end

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             hold_q, hold_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_L_q, cs_L_d;

  logic             half_done;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_next;

  // A half-period ends on the edge where the counter has reached CLK_DIV-1.
  assign half_done = (cnt_q == CW'(CLK_DIV - 1));
  assign tx_ready  = (state_q == S_IDLE);
  assign tx_next   = tx_sh_q << 1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    hold_d     = hold_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_L_d     = cs_L_q;

    // Counter free-runs through each half-period; state entries below
    // force it back to zero.
    if (state_q != S_IDLE) begin
      cnt_d = half_done ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.tx_valid) begin
          tx_sh_d = bus.tx_data;
          hold_d  = bus.tx_hold;
          cs_L_d  = 1'b0;
          mosi_d  = bus.tx_data[WIDTH-1];
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (half_done) begin
          if (!sclk_q) begin
            // Rising edge: peripheral's bit has been stable for a half-period.
            sclk_d  = 1'b1;
            rx_sh_d = (rx_sh_q << 1) | WIDTH'(bus.miso);
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BW'(WIDTH - 1)) begin
              // Last fall: mosi keeps its final bit through the trail.
              cnt_d   = '0;
              state_d = S_TRAIL;
            end else begin
              bit_d   = bit_q + BW'(1);
              tx_sh_d = tx_next;
              mosi_d  = tx_next[WIDTH-1];
            end
          end
        end
      end

      S_TRAIL: begin
        if (half_done) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          if (hold_q) begin
            state_d = S_IDLE;
          end else begin
            cs_L_d  = 1'b1;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      hold_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_L_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      hold_q     <= hold_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_L_q     <= cs_L_d;
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.busy     = ~tx_ready;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_L     = cs_L_q;

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Single-clock SPI controller (mode 0: CPOL=0, CPHA=0; MSB first) that drives sclk, cs_L and mosi, and samples miso.
- It is the FPGA-side initiator for the team's SPI peripheral byte interfaces: it originates the SPI bus that the sclk-domain buffers respond on.
- The user side is a valid/ready byte handshake for transmit and a single-cycle valid pulse for receive.
- Each accepted byte is one full-duplex 8-bit transfer.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 2 (elaboration error otherwise).
- WIDTH, 8, bits per transfer (buffers, bit counter and timing below scale with it).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_L  input  1  asynchronous active-low reset.
- tx_data  input  WIDTH  byte to transmit.
- tx_hold  input  1  sampled with tx_data; 1 = keep cs_L asserted after this byte.
- tx_valid  input  1  tx_data/tx_hold valid.
- tx_ready  output  1  controller can accept a byte (state IDLE).
- rx_data  output  WIDTH  byte received on miso.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  transfer or CS gap in progress (= ~tx_ready).
- sclk  output  1  SPI clock, idles low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in (pre-synchronised by the pad wrapper).
- cs_L  output  1  active-low chip select.

Behaviour:
- Reset (async, any state): sclk=0, cs_L=1, mosi=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0.
- All counters and shift registers clear on reset; an in-flight transfer is abandoned with no rx_valid.
- States and transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> TRAIL after the last falling edge.
  - TRAIL -> IDLE if the hold flag is set, else TRAIL -> GAP.
  - GAP -> IDLE.
- A half-period counter cnt runs 0..CLK_DIV-1 in SHIFT, TRAIL and GAP. It resets on every state entry.
- Accept: at edge T0 where tx_valid && tx_ready.
  - Latch tx_data into the tx shift register and latch tx_hold.
  - cs_L<=0, mosi<=tx_data[WIDTH-1], bit count<=0, enter SHIFT.
- SHIFT timing, with k = 0..WIDTH-1:
  - sclk rises (sclk<=1) at edge T0+D*(2k+1). At that same edge, rx_shift <= {rx_shift, miso}.
  - sclk falls at edge T0+D*(2k+2).
  - On falls k < WIDTH-1, mosi <= next lower bit.
  - On the final fall (T0+2*WIDTH*D), mosi holds its value and the block enters TRAIL.
- TRAIL: lasts D cycles. At edge T0+(2*WIDTH+1)*D:
  - rx_data <= rx_shift and rx_valid <= 1 for exactly one cycle.
  - If hold flag = 0: cs_L <= 1, enter GAP.
  - If hold flag = 1: cs_L stays 0, enter IDLE (tx_ready=1 from the next cycle).
- GAP: cs_L high for D cycles minimum, then IDLE. For WIDTH=8, tx_ready returns at T0+18D.
- Back-to-back with hold: the next accept at T1 follows the same timing relative to T1. The first half-period serves as CS lead; cs_L never glitches high.
- IDLE after a held byte: cs_L stays 0 indefinitely. Only a later byte with tx_hold=0 (or reset) releases it.
- tx_valid while tx_ready=0: ignored. No latching, no state change; the requester must hold tx_valid.
- tx_data/tx_hold changes after acceptance: no effect on the current transfer.
- rx_valid has no backpressure; the consumer must take rx_data on the pulse. rx_data holds its value until the next pulse.
- sclk, mosi and cs_L are registered outputs (glitch-free).

Test Plan:
- CLK_DIV=4: send 0xA5 with tx_hold=0, miso model returns 0x3C (mode 0 slave).
  - Required: cs_L falls at T0.
  - Required: 8 sclk rising edges at T0+4,12,...,60; mosi bits 1,0,1,0,0,1,0,1.
  - Required: rx_valid single pulse with rx_data=0x3C at T0+68; cs_L high at T0+68; tx_ready high at T0+72.
- Send 0x01 (tx_hold=1) then 0xFF (tx_hold=0), tx_valid held high.
  - Required: second accept at T0+69; cs_L low continuously from T0 to T0+69+68.
  - Required: two rx_valid pulses, 68 cycles apart from each accept.
- Pulse tx_valid with 0x55 at T0+10 during a transfer.
  - Required: ignored; only one transfer occurs and tx_ready stays 0 until T0+72.
- Assert rst_L=0 at T0+30 mid-transfer.
  - Required: immediately sclk=0, cs_L=1, mosi=0, tx_ready=1.
  - Required: no rx_valid; after release a new 0x3C transfer completes normally.
- CLK_DIV=2: send 0x80 with miso tied 1.
  - Required: sclk period 4 cycles; rx_data=0xFF, rx_valid at T0+34; mosi high only for bit 7.
- Reset held then released with tx_valid=0.
  - Required: outputs stay at reset values; no sclk activity for 100 cycles.
